// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised simple dual-port RAM.
package ram_pkg;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // Widest word the byte-merge helper handles; the top refuses anything wider.
    localparam int MAX_DW = 512;

    // Read latency in clock edges after the edge that samples re.
    function automatic int read_latency(input int out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

    // Per-byte select: bytes with be set come from new_w, the rest from old_w.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0]   old_w,
        input logic [MAX_DW-1:0]   new_w,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_DW/8; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/param_dual_port_ram_if.sv
// Request/response bundle of the dual-port RAM: write port, read port, status.
interface param_dual_port_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                    we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    re;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   q;
    logic                    q_valid;
    logic                    init_busy;

    modport master (
        output we, w_addr, data, be, re, r_addr,
        input  q, q_valid, init_busy
    );

    modport slave (
        input  we, w_addr, data, be, re, r_addr,
        output q, q_valid, init_busy
    );
endinterface

// File: rtl/sdp_ram_core.sv
// Plain storage array: byte-enabled write port, registered read port, no reset.
module sdp_ram_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   r_addr,
    output logic [DATA_WIDTH-1:0]   q
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write and read in one process: a same-edge read returns the pre-write word.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[w_addr][8*i +: 8] <= data[8*i +: 8];
            end
        end
        if (re) q <= mem[r_addr];
    end
endmodule

// File: rtl/param_dual_port_ram.sv
// Dual-port RAM top: init sweep FSM, write-first bypass merge, read pipeline.
module param_dual_port_ram
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    OUT_REG    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic                  clock,
    input logic                  reset,
    param_dual_port_ram_if.slave bus
);
    localparam int NB     = DATA_WIDTH/8;
    localparam int STAGES = read_latency(OUT_REG);

    generate
        if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MAX_DW) begin : g_bad_width
            $fatal(1, "param_dual_port_ram: DATA_WIDTH must be a multiple of 8");
        end
        if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
            $fatal(1, "param_dual_port_ram: OUT_REG must be 0 or 1");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  ready;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_wa;
    logic [DATA_WIDTH-1:0] core_wd;
    logic [NB-1:0]         core_be;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] core_q;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [NB-1:0]         byp_be;
    logic [DATA_WIDTH-1:0] s1_q;
    logic [STAGES:0]       vld_pipe;

    // FSM state and init sweep counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and write-port mux: the sweep owns the write port during INIT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        core_we   = 1'b0;
        core_wa   = bus.w_addr;
        core_wd   = bus.data;
        core_be   = bus.be;
        case (state)
            ST_INIT: begin
                core_we = 1'b1;
                core_wa = cnt;
                core_wd = INIT_VALUE;
                core_be = '1;
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == '1) state_nxt = ST_READY;
            end
            ST_READY: begin
                ready   = 1'b1;
                core_we = bus.we;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign rd_acc        = ready & bus.re;
    assign bus.init_busy = (state == ST_INIT);

    sdp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clock  (clock),
        .we     (core_we),
        .w_addr (core_wa),
        .data   (core_wd),
        .be     (core_be),
        .re     (rd_acc),
        .r_addr (bus.r_addr),
        .q      (core_q)
    );

    // Valid shift register and capture of a same-address write for the bypass.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            byp_data <= '0;
            byp_be   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_acc};
            if (rd_acc) begin
                byp_data <= bus.data;
                byp_be   <= (bus.we && bus.w_addr == bus.r_addr) ? bus.be : '0;
            end
        end
    end

    // First output stage: overlay written bytes on the pre-write word; holds otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
        end else if (vld_pipe[0]) begin
            s1_q <= DATA_WIDTH'(byte_merge(MAX_DW'(core_q), MAX_DW'(byp_data),
                                           (MAX_DW/8)'(byp_be)));
        end
    end

    generate
        if (OUT_REG == 1) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_q;
            // Extra output register for timing; holds between reads.
            always_ff @(posedge clock or posedge reset) begin
                if (reset)            s2_q <= '0;
                else if (vld_pipe[1]) s2_q <= s1_q;
            end
            assign bus.q = s2_q;
        end else begin : g_noreg
            assign bus.q = s1_q;
        end
    endgenerate

    assign bus.q_valid = vld_pipe[STAGES];
endmodule
